// File: rtl/b16_sram_ctl_if.sv
// Core-side request/response and SRAM pin bundle for the b16 SRAM controller.
// The controller takes the slave view; the core/board environment takes the master view.
interface b16_sram_ctl_if #(
    parameter int l  = 16,
    parameter int AW = 15
);
    logic          drun;
    logic          run;
    logic          sel;
    logic [l-1:0]  cpu_addr;
    logic          cpu_rd;
    logic [1:0]    cpu_wr;
    logic [l-1:0]  cpu_dout;
    logic [l-1:0]  cpu_data;
    logic [AW-1:0] sram_a;
    logic [l-1:0]  sram_dq_o;
    logic          sram_dq_oe;
    logic [l-1:0]  sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    modport master (
        output drun, sel, cpu_addr, cpu_rd, cpu_wr, cpu_dout, sram_dq_i,
        input  run, cpu_data, sram_a, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  drun, sel, cpu_addr, cpu_rd, cpu_wr, cpu_dout, sram_dq_i,
        output run, cpu_data, sram_a, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/b16_sram_ctl.sv
// Wait-stated async SRAM access stage for the b16 core: stalls the core via run
// while a registered SRAM cycle of WAITS+1 clocks completes, then returns read data.
module b16_sram_ctl #(
    parameter int l     = 16,
    parameter int AW    = 15,
    parameter int WAITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    b16_sram_ctl_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [l-1:0]  data_q, data_d;
    logic [AW-1:0] a_q, a_d;
    logic [l-1:0]  dq_q, dq_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          ub_n_q, ub_n_d;
    logic          lb_n_q, lb_n_d;

    logic req, is_wr;
    logic unused_addr_lsb;

    assign unused_addr_lsb = bus.cpu_addr[0];
    assign is_wr = |bus.cpu_wr;
    assign req   = bus.sel & (bus.cpu_rd | is_wr);

    // Drop run in the request cycle itself so the core holds its request stable.
    assign bus.run = bus.drun & ~reset & ~((state_q == IDLE) & req) & (state_q != ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        a_d     = a_q;
        dq_d    = dq_q;
        dq_oe_d = dq_oe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
        case (state_q)
            IDLE: begin
                if (req && bus.drun) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAITS);
                    a_d     = bus.cpu_addr[AW:1];
                    dq_d    = bus.cpu_dout;
                    ce_n_d  = 1'b0;
                    if (is_wr) begin
                        we_n_d  = 1'b0;
                        dq_oe_d = 1'b1;
                        ub_n_d  = ~bus.cpu_wr[1];
                        lb_n_d  = ~bus.cpu_wr[0];
                    end else begin
                        oe_n_d = 1'b0;
                        ub_n_d = 1'b0;
                        lb_n_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    // oe_n low marks a read cycle; writes leave cpu_data untouched
                    if (!oe_n_q) data_d = bus.sram_dq_i;
                    cnt_d   = 4'd0;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // dq_oe keeps driving write data until the core consumes the access
                if (bus.drun) begin
                    state_d = IDLE;
                    dq_oe_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            a_q     <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            a_q     <= a_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
        end
    end

    assign bus.cpu_data   = data_q;
    assign bus.sram_a     = a_q;
    assign bus.sram_dq_o  = dq_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_ub_n  = ub_n_q;
    assign bus.sram_lb_n  = lb_n_q;
endmodule

// File: tb/tb_b16_sram_ctl.sv
// Directed bench for b16_sram_ctl: main instance at WAITS=2, a WAITS=0 twin shares its inputs.
module tb_b16_sram_ctl;
    localparam int L  = 16;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    b16_sram_ctl_if #(.l(L), .AW(AW)) bus  ();
    b16_sram_ctl_if #(.l(L), .AW(AW)) bus0 ();

    b16_sram_ctl #(.l(L), .AW(AW), .WAITS(2)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    b16_sram_ctl #(.l(L), .AW(AW), .WAITS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    assign bus0.drun      = bus.drun;
    assign bus0.sel       = bus.sel;
    assign bus0.cpu_addr  = bus.cpu_addr;
    assign bus0.cpu_rd    = bus.cpu_rd;
    assign bus0.cpu_wr    = bus.cpu_wr;
    assign bus0.cpu_dout  = bus.cpu_dout;
    assign bus0.sram_dq_i = bus.sram_dq_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.sel    = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 2'b00;
    endtask

    // Walks one access from the request cycle to the first run-high cycle (DONE).
    task automatic run_access(output int low, output int ce_low, output int oe_low,
                              output int we_low, output logic [AW-1:0] a,
                              output logic ub, output logic lb, output logic dqoe,
                              output logic [L-1:0] dq, output logic [3:0] h0,
                              output logic [L-1:0] d0);
        low = 0; ce_low = 0; oe_low = 0; we_low = 0;
        a = '0; ub = 1'b1; lb = 1'b1; dqoe = 1'b0; dq = '0; h0 = '0; d0 = '0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) h0[i] = bus0.run;
            if (i == 2) d0 = bus0.cpu_data;
            if (bus.run === 1'b1) break;
            low++;
            if (!bus.sram_ce_n) begin
                ce_low++;
                a = bus.sram_a; ub = bus.sram_ub_n; lb = bus.sram_lb_n;
                dqoe = bus.sram_dq_oe; dq = bus.sram_dq_o;
            end
            if (!bus.sram_oe_n) oe_low++;
            if (!bus.sram_we_n) we_low++;
            step;
        end
        chk("access_timeout", 32'(low < 20), 32'd1);
    endtask

    int low, ce_low, oe_low, we_low, n;
    logic [AW-1:0] a;
    logic ub, lb, dqoe;
    logic [L-1:0] dq, d0;
    logic [3:0] h0;

    initial begin
        reset = 1'b1;
        bus.drun = 1'b1;
        idle_inputs();
        bus.cpu_addr = '0; bus.cpu_dout = '0; bus.sram_dq_i = '0;
        repeat (3) step;
        chk("rst_run", bus.run, 1'b0);
        chk("rst_strobes_n", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b11111);
        chk("rst_dq_oe", bus.sram_dq_oe, 1'b0);
        chk("rst_cpu_data", bus.cpu_data, 16'h0000);
        chk("rst_sram_a", bus.sram_a, 15'h0000);
        chk("rst_dq_o", bus.sram_dq_o, 16'h0000);
        reset = 1'b0;
        step;
        chk("post_rst_run", bus.run, 1'b1);

        // Reset landing in the second ACCESS cycle of a read
        bus.sel = 1'b1; bus.cpu_rd = 1'b1; bus.cpu_addr = 16'h0002; bus.sram_dq_i = 16'h5555;
        #1 chk("abort_req_run", bus.run, 1'b0);
        step;
        chk("abort_acc1_ce_oe", {bus.sram_ce_n, bus.sram_oe_n}, 2'b00);
        step;
        reset = 1'b1;
        #1 chk("abort_rst_run", bus.run, 1'b0);
        step;
        reset = 1'b0; idle_inputs();
        #1;
        chk("abort_strobes_n", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b11111);
        chk("abort_cpu_data", bus.cpu_data, 16'h0000);
        chk("abort_run", bus.run, 1'b1);
        step;
        chk("abort_stay_idle", bus.sram_ce_n, 1'b1);

        // Read 0x1234 -> word 0x091A, data 0xBEEF
        bus.sel = 1'b1; bus.cpu_rd = 1'b1; bus.cpu_addr = 16'h1234; bus.sram_dq_i = 16'hBEEF;
        run_access(low, ce_low, oe_low, we_low, a, ub, lb, dqoe, dq, h0, d0);
        chk("rd_run_low", low, 4);
        chk("rd_ce_low", ce_low, 3);
        chk("rd_oe_low", oe_low, 3);
        chk("rd_we_low", we_low, 0);
        chk("rd_sram_a", a, 15'h091A);
        chk("rd_ub_lb", {ub, lb}, 2'b00);
        chk("rd_dq_oe", dqoe, 1'b0);
        chk("rd_done_data", bus.cpu_data, 16'hBEEF);
        chk("rd_done_strobes", {bus.sram_ce_n, bus.sram_oe_n}, 2'b11);
        chk("rd_done_a_held", bus.sram_a, 15'h091A);
        chk("w0_run_hist", h0, 4'b0100);
        chk("w0_data", d0, 16'hBEEF);
        idle_inputs();
        step;
        chk("rd_idle_run", bus.run, 1'b1);
        chk("rd_idle_ce", bus.sram_ce_n, 1'b1);

        // High-byte write
        bus.sel = 1'b1; bus.cpu_wr = 2'b10; bus.cpu_addr = 16'h0010;
        bus.cpu_dout = 16'hAB00; bus.sram_dq_i = 16'h7777;
        run_access(low, ce_low, oe_low, we_low, a, ub, lb, dqoe, dq, h0, d0);
        chk("wr_run_low", low, 4);
        chk("wr_we_low", we_low, 3);
        chk("wr_oe_low", oe_low, 0);
        chk("wr_ub_lb", {ub, lb}, 2'b01);
        chk("wr_dq_o", dq, 16'hAB00);
        chk("wr_dq_oe_acc", dqoe, 1'b1);
        chk("wr_sram_a", a, 15'h0008);
        chk("wr_done_dq_oe", bus.sram_dq_oe, 1'b1);
        chk("wr_done_dq_o", bus.sram_dq_o, 16'hAB00);
        chk("wr_done_we", bus.sram_we_n, 1'b1);
        chk("wr_cpu_data", bus.cpu_data, 16'hBEEF);
        idle_inputs();
        step;
        chk("wr_idle_dq_oe", bus.sram_dq_oe, 1'b0);
        chk("wr_idle_run", bus.run, 1'b1);

        // Off-SRAM access never stalls
        bus.sel = 1'b0; bus.cpu_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("nosel_run", bus.run, 1'b1);
            chk("nosel_strobes", {bus.sram_ce_n, bus.sram_oe_n}, 2'b11);
            step;
        end

        // Request without debugger run starts nothing
        bus.drun = 1'b0; bus.sel = 1'b1; bus.cpu_addr = 16'h0040;
        #1 chk("nodrun_run", bus.run, 1'b0);
        step;
        chk("nodrun_ce", bus.sram_ce_n, 1'b1);

        // drun dropped mid-access: finish, park in DONE, single run pulse
        bus.drun = 1'b1; bus.cpu_addr = 16'h0100; bus.sram_dq_i = 16'h1357;
        #1 chk("hold_req_run", bus.run, 1'b0);
        step;
        bus.drun = 1'b0;
        #1 chk("hold_acc_ce", bus.sram_ce_n, 1'b0);
        n = 0;
        while (bus.sram_ce_n !== 1'b1 && n < 10) begin
            step;
            n++;
        end
        chk("hold_acc_len", n, 3);
        chk("hold_done_data", bus.cpu_data, 16'h1357);
        for (int i = 0; i < 3; i++) begin
            chk("hold_done_run", bus.run, 1'b0);
            chk("hold_done_ce", bus.sram_ce_n, 1'b1);
            step;
        end
        idle_inputs(); bus.drun = 1'b1;
        #1 chk("hold_pulse_run", bus.run, 1'b1);
        step;
        chk("hold_idle_run", bus.run, 1'b1);
        chk("hold_idle_ce", bus.sram_ce_n, 1'b1);
        step;
        chk("hold_no_repeat", {bus.sram_ce_n, bus.sram_oe_n}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/b16_sram_ctl.md
Name: b16_sram_ctl

Overview:
- Downstream memory stage for the b16 core.
- Consumes the core's bus request (`addr`, `rd`, `wr[1:0]`, `dataout`) and runs a wait-stated cycle on an external asynchronous 16-bit SRAM.
- Stalls the core by holding its `run` input low until the access completes, then returns the read word on the core's `data` input.
- Sits between the core/debugger pair and the board SRAM. It gates the debugger's run request, so the core advances only when both allow it.

Parameters:
- l, 16, data word width.
- AW, 15, SRAM word-address width; sram_a = cpu_addr[AW:1].
- WAITS, 2, extra ACCESS cycles beyond the first (legal 0..15); ACCESS lasts WAITS+1 cycles.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- drun  in  1  run request from the debugger.
- run  out  1  run enable to the core.
- sel  in  1  current core access targets external SRAM (address decode done outside).
- cpu_addr  in  l  core byte address.
- cpu_rd  in  1  core read request.
- cpu_wr  in  2  core byte-lane write strobes; [1] = high byte (even address), [0] = low byte.
- cpu_dout  in  l  core write data, already lane-ordered.
- cpu_data  out  l  read data to the core.
- sram_a  out  AW  SRAM word address.
- sram_dq_o  out  l  SRAM write data.
- sram_dq_oe  out  1  drive enable for the SRAM data pads.
- sram_dq_i  in  l  SRAM read data.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_ub_n  out  1  upper-byte enable, active low.
- sram_lb_n  out  1  lower-byte enable, active low.

Behaviour:
- Request: req = sel & (cpu_rd | |cpu_wr). Write wins if rd and wr are both set (the core never does this).
- run (combinational) = drun & ~reset & ~(state==IDLE & req) & (state!=ACCESS).
  - The core sees run low in the same cycle a request appears, so the request stays stable.
- Reset values:
  - state=IDLE, cnt=0, run=0.
  - cpu_data=0, sram_a=0, sram_dq_o=0, sram_dq_oe=0.
  - All *_n outputs = 1.
  - Reset mid-access aborts immediately; no data is latched.
- IDLE:
  - If req & drun: on the clock edge, register sram_a, sram_dq_o <= cpu_dout, and cnt <= WAITS; drive ce_n=0; go to ACCESS.
  - Read request: oe_n=0, ub_n=lb_n=0.
  - Write request: we_n=0, dq_oe=1, ub_n=~cpu_wr[1], lb_n=~cpu_wr[0].
  - If req & ~drun: no access starts.
  - If ~req: remain IDLE; the core runs freely (no stall for sel=0 accesses).
- ACCESS:
  - cnt decrements each edge.
  - On the edge where cnt==0:
    - On a read, cpu_data <= sram_dq_i.
    - ce_n, oe_n, we_n, ub_n, lb_n <= 1.
    - Go to DONE.
  - sram_a and sram_dq_o are held stable through DONE.
- DONE:
  - run = drun.
  - dq_oe stays at its ACCESS value (write-data hold) and clears on exit.
  - On an edge with drun=1, go to IDLE (the core consumed the access).
  - If drun=0, remain in DONE; the access is never repeated.
- Latency:
  - run is low for exactly WAITS+2 cycles (request cycle plus WAITS+1 ACCESS cycles).
  - run is high in DONE; the next access can start in the cycle after DONE.
- cpu_data holds the last read value; writes do not change it.
- Back-to-back requests (e.g. fetch then load) each take the full sequence; there is no pipelining.
- WAITS=0: ACCESS lasts one cycle and the stall is 2 cycles.

Test Plan:
- Reset asserted 3 cycles with drun=1 → run=0, all *_n=1, dq_oe=0, cpu_data=0; after release with req=0 → run=1 next cycle.
- WAITS=2, read addr 0x1234, sram_dq_i=0xBEEF → run low 4 cycles; sram_a=0x091A; ce_n/oe_n low 3 cycles; cpu_data=0xBEEF in DONE; run=1 for one cycle, then IDLE.
- Byte write: cpu_wr=2'b10, addr 0x0010, cpu_dout=0xAB00 → ub_n=0, lb_n=1, we_n low 3 cycles, dq_o=0xAB00, dq_oe high through DONE; cpu_data unchanged.
- sel=0 with cpu_rd=1 → run stays 1; no SRAM strobe toggles.
- drun dropped during ACCESS → access completes; FSM waits in DONE with run=0; drun=1 → single run pulse; no second SRAM cycle.
- Reset asserted in the 2nd ACCESS cycle → next cycle state=IDLE, strobes high, cpu_data keeps its previous value (reset value 0).
